mio_arbiter: RTL
================

MIO_ARBITER -- requirements
Module: mio_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: memory access cycles per transaction; legal range 1..15.
REQ-002 Parameter AW, default 32: address width for both requesters and the memory port.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 CPU_MIO  input  1  CPU memory/IO request, held high until MIO_ready.
REQ-006 MemRead  input  1  CPU read qualifier.
REQ-007 MemWrite  input  1  CPU write qualifier.
REQ-008 cpu_addr  input  AW  CPU address.
REQ-009 cpu_wdata  input  32  CPU write data.
REQ-010 MIO_ready  output  1  one-cycle CPU completion pulse.
REQ-011 dma_req  input  1  secondary requester request, held until dma_ack.
REQ-012 dma_we  input  1  secondary requester write enable.
REQ-013 dma_addr  input  AW  secondary requester address.
REQ-014 dma_wdata  input  32  secondary requester write data.
REQ-015 dma_ack  output  1  one-cycle secondary requester completion pulse.
REQ-016 rd_data  output  32  read data, valid in the cycle of MIO_ready or dma_ack.
REQ-017 mem_en, mem_we  output  1 each  memory strobe and write enable.
REQ-018 mem_addr  output  AW  registered memory address.
REQ-019 mem_wdata  output  32  registered memory write data.
REQ-020 mem_rdata  input  32  memory read data.
REQ-021 state_out  output  2  current FSM state code, for debug.

Function
REQ-022 FSM states and codes: IDLE=0, ACCESS=1, RESP=2; code 3 is unreachable and recovers to IDLE.
REQ-023 A CPU request is CPU_MIO & (MemRead | MemWrite); CPU_MIO without a qualifier is ignored.
REQ-024 IDLE with any request: pick a winner, register its addr/wdata/we into mem_*, load the wait counter with WAIT_CYCLES-1, and go to ACCESS.
REQ-025 ACCESS: mem_en=1 and mem_we=latched we; decrement the counter; at counter 0, capture mem_rdata into rd_data and go to RESP.
REQ-026 RESP: pulse MIO_ready or dma_ack, per the winner, for exactly one cycle, then go to IDLE; mem_en=0.
REQ-027 Latency: a request first seen in IDLE at edge N gets its completion pulse in cycle N+WAIT_CYCLES+1.
REQ-028 Back-to-back: a request still high in the IDLE cycle after RESP starts a new transaction; there is no extra bubble.
REQ-029 Requests arriving during ACCESS or RESP wait; no pre-emption.
REQ-030 Request dropped mid-transaction: the access completes and the pulse is still issued; the requester ignores it.
REQ-031 Write: rd_data holds its previous value.
REQ-032 Exactly one of MIO_ready and dma_ack may be high in any cycle.

Reset
REQ-033 reset low forces the following immediately, regardless of the current state:
- state IDLE
- all outputs 0, including rd_data and mem_*
- counter 0
- last-grant flag set to DMA
REQ-034 An in-flight transaction is abandoned and no pulse is issued.

Configuration
REQ-035 ARB_RR_EN defined: round-robin tie-break; a simultaneous request goes to the requester that did not win last; the flag updates on entry to ACCESS.
REQ-036 ARB_RR_EN undefined: fixed priority, CPU wins every tie; the last-grant flag is not implemented.

Structure
REQ-037 State encodings and the winner enum (CPU=0, DMA=1) belong in shared package mio_pkg.
REQ-038 The wait counter is a natural sub-module: mio_wait_cnt (load, decrement, zero flag).

Verification (WAIT_CYCLES=2)
REQ-039 CPU read at 0x10, mem_rdata=0xDEADBEEF: mem_en high 2 cycles; MIO_ready and rd_data=0xDEADBEEF in the 3rd cycle.
REQ-040 DMA write at 0x20 with data 0x55: mem_we=1, mem_addr=0x20, mem_wdata=0x55 for 2 cycles; dma_ack 1 cycle; MIO_ready stays 0.
REQ-041 Both requesters held high continuously:
- with ARB_RR_EN, grants alternate CPU, DMA, CPU, DMA
- without ARB_RR_EN, DMA is never granted
REQ-042 CPU_MIO=1 with MemRead=MemWrite=0: FSM stays IDLE and mem_en stays 0.
REQ-043 reset low in the 2nd ACCESS cycle: state_out=0, mem_en=0, and no ack pulse; after release, a held request restarts from ACCESS.

Source files
------------

// File: rtl/mio_pkg.sv
// Shared types for the MIO arbiter: FSM state codes, requester identity, counter width.
package mio_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  typedef enum logic {
    WinCpu = 1'b0,
    WinDma = 1'b1
  } winner_e;

  localparam int unsigned CntW = 4;

endpackage

// File: rtl/mio_wait_cnt.sv
// Memory wait-state counter: loadable down-counter with a zero flag.
module mio_wait_cnt
  import mio_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic [CntW-1:0] i_load_val,
  input  logic            i_dec,
  output logic            o_zero
);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mio_arbiter.sv
// Two-requester (CPU, DMA) memory arbiter with a fixed-latency access FSM.
// Define ARB_RR_EN for round-robin tie-break; otherwise the CPU wins every tie.
module mio_arbiter
  import mio_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned AW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          CPU_MIO,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          MIO_ready,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [31:0]   dma_wdata,
  output logic          dma_ack,
  output logic [31:0]   rd_data,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [1:0]    state_out
);

  state_e          r_state;
  winner_e         r_owner;
  logic            r_mio_ready;
  logic            r_dma_ack;
  logic [31:0]     r_rd_data;
  logic            r_mem_en;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [31:0]     r_mem_wdata;
`ifdef ARB_RR_EN
  winner_e         r_last;
`endif

  logic            w_cpu_req;
  logic            w_any_req;
  winner_e         w_win;
  logic            w_win_we;
  logic [AW-1:0]   w_win_addr;
  logic [31:0]     w_win_wdata;
  logic            w_load;
  logic            w_dec;
  logic            w_cnt_zero;

  // A bare CPU_MIO without a read/write qualifier is not a request.
  assign w_cpu_req = CPU_MIO & (MemRead | MemWrite);
  assign w_any_req = w_cpu_req | dma_req;

  always_comb begin
`ifdef ARB_RR_EN
    if (w_cpu_req && dma_req) begin
      w_win = (r_last == WinCpu) ? WinDma : WinCpu;
    end else begin
      w_win = w_cpu_req ? WinCpu : WinDma;
    end
`else
    w_win = w_cpu_req ? WinCpu : WinDma;
`endif
    w_win_we    = (w_win == WinCpu) ? MemWrite  : dma_we;
    w_win_addr  = (w_win == WinCpu) ? cpu_addr  : dma_addr;
    w_win_wdata = (w_win == WinCpu) ? cpu_wdata : dma_wdata;
  end

  assign w_load = (r_state == StIdle) && w_any_req;
  assign w_dec  = (r_state == StAccess) && !w_cnt_zero;

  mio_wait_cnt u_wait_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (CntW'(WAIT_CYCLES - 1)),
    .i_dec      (w_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_owner     <= WinCpu;
      r_mio_ready <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_rd_data   <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef ARB_RR_EN
      r_last      <= WinDma;
`endif
    end else begin
      r_mio_ready <= 1'b0;
      r_dma_ack   <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_state     <= StAccess;
            r_owner     <= w_win;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_win_we;
            r_mem_addr  <= w_win_addr;
            r_mem_wdata <= w_win_wdata;
`ifdef ARB_RR_EN
            r_last      <= w_win;
`endif
          end
        end
        StAccess: begin
          if (w_cnt_zero) begin
            // r_mem_we still holds the latched direction on this final access edge.
            if (!r_mem_we) begin
              r_rd_data <= mem_rdata;
            end
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mio_ready <= (r_owner == WinCpu);
            r_dma_ack   <= (r_owner == WinDma);
            r_state     <= StResp;
          end
        end
        StResp: begin
          r_state <= StIdle;
        end
        default: begin
          r_state  <= StIdle;
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

  assign MIO_ready = r_mio_ready;
  assign dma_ack   = r_dma_ack;
  assign rd_data   = r_rd_data;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign state_out = r_state;

endmodule
